// File: rtl/vending_pkg.sv
// Shared types and coin decode for the change-giving vending machine.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    // Coin value in 5-won units.
    function automatic logic [2:0] coin_units(input logic [1:0] coin);
        case (coin)
            COIN_5:  coin_units = 3'd1;
            COIN_10: coin_units = 3'd2;
            COIN_20: coin_units = 3'd4;
            default: coin_units = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vending_machine_change.sv
// Coin-accumulating vending controller: vends at PRICE_UNITS, returns excess
// as 5-won change pulses, supports cancel/refund, stock tracking and refill.
module vending_machine_change
    import vending_pkg::*;
#(
    parameter int PRICE_UNITS = 3,
    parameter int CREDIT_W    = 4,
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                refill,
    output logic                newspaper,
    output logic                change_5,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                sold_out,
    output logic                busy
);

    // Three extra bits so credit plus the largest coin never wraps.
    localparam int SUM_W = CREDIT_W + 3;
    localparam logic [SUM_W-1:0]   MAX_CREDIT = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [SUM_W-1:0]   PRICE      = SUM_W'(PRICE_UNITS);
    localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [STOCK_W-1:0]  r_stock, w_stock_nxt;
    logic                r_coin_reject, w_coin_reject_nxt;

    logic [SUM_W-1:0]    w_sum;
    logic [SUM_W-1:0]    w_sum_less_price;
    logic                w_coin_present;
    logic                w_coin_bad;
    logic                w_coin_accept;
    logic                w_sold_out;

    assign w_sold_out     = (r_stock == '0);
    assign w_coin_present = (coin != COIN_NONE);
    assign w_sum          = SUM_W'(r_credit) + SUM_W'(coin_units(coin));
    assign w_sum_less_price = w_sum - PRICE;
    assign w_coin_bad     = w_sold_out || cancel || (w_sum > MAX_CREDIT);
    assign w_coin_accept  = w_coin_present && !w_coin_bad;

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_stock_nxt       = r_stock;
        w_coin_reject_nxt = 1'b0;

        case (r_state)
            IDLE, ACCUM: begin
                if (w_coin_present && w_coin_bad) begin
                    w_coin_reject_nxt = 1'b1;
                end else if (w_coin_accept) begin
                    if (w_sum >= PRICE) begin
                        w_state_nxt  = VEND;
                        w_credit_nxt = w_sum_less_price[CREDIT_W-1:0];
                        w_stock_nxt  = r_stock - 1'b1;
                    end else begin
                        w_state_nxt  = ACCUM;
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                    end
                end

                // A coin arriving with cancel is already rejected above, so
                // the refund covers only the credit held before this cycle.
                if (r_state == ACCUM && cancel) begin
                    w_state_nxt = CHANGE;
                end else if (r_state == IDLE && refill && !w_coin_accept) begin
                    w_stock_nxt = STOCK_INIT;
                end
            end
            VEND: begin
                w_coin_reject_nxt = w_coin_present;
                w_state_nxt       = (r_credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                w_coin_reject_nxt = w_coin_present;
                if (r_credit <= CREDIT_W'(1)) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_credit_nxt = r_credit - 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_stock       <= STOCK_INIT;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_stock       <= w_stock_nxt;
            r_coin_reject <= w_coin_reject_nxt;
        end
    end

    assign newspaper   = (r_state == VEND);
    assign change_5    = (r_state == CHANGE);
    assign busy        = (r_state == VEND) || (r_state == CHANGE);
    assign coin_reject = r_coin_reject;
    assign credit      = r_credit;
    assign stock       = r_stock;
    assign sold_out    = w_sold_out;

endmodule

// File: tb/tb_vending_machine_change.sv
// Directed bench: default instance (price 3, stock 8) plus a stock-1 instance.
module tb_vending_machine_change;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] coin, coin1;
    logic       cancel, cancel1, refill, refill1;

    logic       newspaper, change_5, coin_reject, sold_out, busy;
    logic [3:0] credit, stock;
    logic       newspaper1, change_51, coin_reject1, sold_out1, busy1;
    logic [3:0] credit1, stock1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vending_machine_change u_dut (
        .clk(clk), .rstn(rstn), .coin(coin), .cancel(cancel), .refill(refill),
        .newspaper(newspaper), .change_5(change_5), .coin_reject(coin_reject),
        .credit(credit), .stock(stock), .sold_out(sold_out), .busy(busy)
    );

    vending_machine_change #(.INIT_STOCK(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .coin(coin1), .cancel(cancel1), .refill(refill1),
        .newspaper(newspaper1), .change_5(change_51), .coin_reject(coin_reject1),
        .credit(credit1), .stock(stock1), .sold_out(sold_out1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [3:0] e_credit,
                              input logic e_news, input logic e_chg,
                              input logic e_rej, input logic e_busy);
        check({tag, ".credit"},      32'(credit),      32'(e_credit));
        check({tag, ".newspaper"},   32'(newspaper),   32'(e_news));
        check({tag, ".change_5"},    32'(change_5),    32'(e_chg));
        check({tag, ".coin_reject"}, 32'(coin_reject), 32'(e_rej));
        check({tag, ".busy"},        32'(busy),        32'(e_busy));
    endtask

    initial begin
        rstn = 1'b0; coin = 2'b00; cancel = 1'b0; refill = 1'b0;
        coin1 = 2'b00; cancel1 = 1'b0; refill1 = 1'b0;
        step(); step();
        rstn = 1'b1;
        check_main("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.stock", 32'(stock), 32'd8);
        check("reset.sold_out", 32'(sold_out), 32'd0);
        check("reset.stock1", 32'(stock1), 32'd1);

        // three 5-won coins: exact price, no change
        coin = 2'b01; step(); check_main("t1a", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();               check_main("t1b", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();               check_main("t1c", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t1c.stock", 32'(stock), 32'd7);
        coin = 2'b00; step(); check_main("t1d", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 10 + 10: vend with one unit of change
        coin = 2'b10; step(); check_main("t2a", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();               check_main("t2b", 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t2b.stock", 32'(stock), 32'd6);
        coin = 2'b00; step(); check_main("t2c", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();               check_main("t2d", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 20 won, then a coin during VEND is rejected
        coin = 2'b11; step(); check_main("t3a", 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t3a.stock", 32'(stock), 32'd5);
        coin = 2'b10; step(); check_main("t3b", 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        coin = 2'b00; step(); check_main("t3c", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // cancel refunds two units
        coin = 2'b01; step(); step(); check_main("t4a", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        coin = 2'b00; cancel = 1'b1; step(); check_main("t4b", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        cancel = 1'b0; step(); check_main("t4c", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();                check_main("t4d", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4d.stock", 32'(stock), 32'd5);

        // cancel together with a coin: coin rejected, only prior credit refunded
        coin = 2'b01; step(); check_main("t5a", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        coin = 2'b10; cancel = 1'b1; step(); check_main("t5b", 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        coin = 2'b00; cancel = 1'b0; step(); check_main("t5c", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5c.stock", 32'(stock), 32'd5);

        // refill in IDLE
        refill = 1'b1; step(); refill = 1'b0;
        check("t6.stock", 32'(stock), 32'd8);

        // refill ignored while accumulating
        coin = 2'b01; step(); coin = 2'b00; refill = 1'b1; step(); refill = 1'b0;
        coin = 2'b01; step(); coin = 2'b10; step();
        check("t7.vend", 32'(newspaper), 32'd1);
        check("t7.stock", 32'(stock), 32'd7);
        check("t7.credit", 32'(credit), 32'd1);
        coin = 2'b00; step(); step();
        refill = 1'b1; step(); refill = 1'b0;
        check("t7.refill", 32'(stock), 32'd8);

        // stock-1 instance: sell out, reject, refill
        coin1 = 2'b11; step();
        check("s1.newspaper", 32'(newspaper1), 32'd1);
        check("s1.stock", 32'(stock1), 32'd0);
        check("s1.sold_out", 32'(sold_out1), 32'd1);
        coin1 = 2'b00; step(); step();
        check("s1.idle", 32'(busy1), 32'd0);
        coin1 = 2'b01; step();
        check("s2.reject", 32'(coin_reject1), 32'd1);
        check("s2.credit", 32'(credit1), 32'd0);
        check("s2.newspaper", 32'(newspaper1), 32'd0);
        coin1 = 2'b00; refill1 = 1'b1; step(); refill1 = 1'b0;
        check("s3.stock", 32'(stock1), 32'd1);
        check("s3.sold_out", 32'(sold_out1), 32'd0);
        check("s3.reject", 32'(coin_reject1), 32'd0);

        // reset during CHANGE with three units pending
        coin = 2'b01; step(); step();
        coin = 2'b11; step(); check_main("r1", 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        check("r1.stock", 32'(stock), 32'd7);
        coin = 2'b00; step(); check_main("r2", 4'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        rstn = 1'b0; step(); check_main("r3", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("r3.stock", 32'(stock), 32'd8);
        rstn = 1'b1; step(); check_main("r4", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
